// File: rtl/sd_pic_rd_sched.sv
// -----------------------------------------------------------------------------
// sd_pic_rd_sched
//   Reads one full picture from the SD card, one sector at a time, once card
//   init is complete. Each sector is requested from sd_ctrl only when the
//   SDRAM write FIFO has room for the whole sector. Incoming sector words are
//   forwarded (registered, one cycle of latency) into that FIFO.
//   The block reports a one-cycle pic_done pulse when every sector has been
//   delivered. It raises a sticky err on a timeout or on a sector whose word
//   count is wrong.
//
// Ports
//   sys_clk       in   1      50 MHz clock
//   sys_rst_n     in   1      asynchronous reset, active low
//   init_end      in   1      SD card init complete (level)
//   start         in   1      one-cycle pulse: read a picture (IDLE only)
//   rd_busy       in   1      sd_ctrl read in progress
//   rd_data_en    in   1      rd_data valid strobe
//   rd_data       in   16     sector data word
//   fifo_free     in   CNT_W  free words in the write FIFO
//   rd_en         out  1      read request to sd_ctrl
//   rd_addr       out  32     sector address to sd_ctrl
//   wr_fifo_en    out  1      FIFO write strobe
//   wr_fifo_data  out  16     FIFO write data
//   busy          out  1      picture read in progress
//   pic_done      out  1      one-cycle pulse: picture complete
//   err           out  1      sticky error, cleared only by reset
// -----------------------------------------------------------------------------
module sd_pic_rd_sched #(
  parameter logic [31:0] START_SECTOR  = 32'd16640,
  parameter logic [31:0] SECTOR_NUM    = 32'd1200,
  parameter logic [8:0]  WORDS_PER_SEC = 9'd256,
  parameter int          CNT_W         = 11,
  parameter logic [23:0] TIMEOUT       = 24'd5_000_000,
  parameter bit          AUTO_START    = 1'b1
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             init_end,
  input  logic             start,
  input  logic             rd_busy,
  input  logic             rd_data_en,
  input  logic [15:0]      rd_data,
  input  logic [CNT_W-1:0] fifo_free,
  output logic             rd_en,
  output logic [31:0]      rd_addr,
  output logic             wr_fifo_en,
  output logic [15:0]      wr_fifo_data,
  output logic             busy,
  output logic             pic_done,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPACE,
    S_REQ,
    S_RD,
    S_NEXT,
    S_DONE
  } state_t;

  // The word counter is one bit wider than the sector size so that a surplus
  // word can be told apart from an exact count at the end of the sector.
  localparam logic [9:0] WPS = {1'b0, WORDS_PER_SEC};

  state_t        state_reg, state_next;
  logic [31:0]   sector_cnt_reg, sector_cnt_next;
  logic [9:0]    word_cnt_reg, word_cnt_next;
  logic [23:0]   tmo_cnt_reg, tmo_cnt_next;
  logic          err_reg, err_next;
  logic          rd_en_reg, rd_en_next;
  logic [31:0]   rd_addr_reg, rd_addr_next;
  logic          wr_en_reg, wr_en_next;
  logic [15:0]   wr_data_reg, wr_data_next;
  logic          pic_done_reg, pic_done_next;
  logic          init_end_d_reg;
  logic          rd_busy_d_reg;

  logic          init_rise;
  logic          busy_fall;
  logic          go;
  logic          free_ok;
  logic          tmo_hit;

  assign init_rise = init_end && !init_end_d_reg;
  assign busy_fall = rd_busy_d_reg && !rd_busy;
  // A start pulse and an init_end edge in the same cycle simply both request
  // the same single run.
  assign go        = (start || (AUTO_START && init_rise)) && init_end && !err_reg;
  assign free_ok   = 32'(fifo_free) >= 32'(WORDS_PER_SEC);
  // The counter starts at 0 on state entry, so TIMEOUT-1 marks the end of
  // TIMEOUT full cycles spent waiting.
  assign tmo_hit   = (tmo_cnt_reg == TIMEOUT - 24'd1);

  always_comb begin
    state_next      = state_reg;
    sector_cnt_next = sector_cnt_reg;
    word_cnt_next   = word_cnt_reg;
    err_next        = err_reg;
    rd_addr_next    = rd_addr_reg;
    wr_en_next      = 1'b0;
    wr_data_next    = wr_data_reg;

    case (state_reg)
      S_IDLE: begin
        sector_cnt_next = 32'd0;
        word_cnt_next   = 10'd0;
        if (go) state_next = S_SPACE;
      end
      S_SPACE: begin
        if (free_ok) begin
          state_next   = S_REQ;
          rd_addr_next = START_SECTOR + sector_cnt_reg;
        end
      end
      S_REQ: begin
        if (rd_busy) state_next = S_RD;
      end
      S_RD: begin
        if (rd_data_en) begin
          // Surplus words are dropped; the counter still moves past WPS so
          // the mismatch is caught when the sector ends.
          if (word_cnt_reg < WPS) begin
            wr_en_next   = 1'b1;
            wr_data_next = rd_data;
          end
          if (word_cnt_reg <= WPS) word_cnt_next = word_cnt_reg + 10'd1;
        end
        if (busy_fall) state_next = S_NEXT;
      end
      S_NEXT: begin
        if (word_cnt_reg != WPS) begin
          err_next   = 1'b1;
          state_next = S_IDLE;
        end else begin
          word_cnt_next   = 10'd0;
          sector_cnt_next = sector_cnt_reg + 32'd1;
          state_next      = (sector_cnt_reg + 32'd1 == SECTOR_NUM) ? S_DONE : S_SPACE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Losing the card aborts silently; a stalled transfer aborts with err.
    if (state_reg != S_IDLE && !init_end) begin
      state_next = S_IDLE;
      wr_en_next = 1'b0;
    end else if ((state_reg == S_REQ || state_reg == S_RD) && tmo_hit) begin
      err_next   = 1'b1;
      state_next = S_IDLE;
    end

    if (state_next == S_IDLE) rd_addr_next = 32'd0;

    if (state_next == state_reg && (state_reg == S_REQ || state_reg == S_RD))
      tmo_cnt_next = tmo_cnt_reg + 24'd1;
    else
      tmo_cnt_next = 24'd0;

    // Registered from the next state so rd_en and pic_done line up exactly
    // with the REQ and DONE states.
    rd_en_next    = (state_next == S_REQ);
    pic_done_next = (state_next == S_DONE);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg      <= S_IDLE;
      sector_cnt_reg <= 32'd0;
      word_cnt_reg   <= 10'd0;
      tmo_cnt_reg    <= 24'd0;
      err_reg        <= 1'b0;
      rd_en_reg      <= 1'b0;
      rd_addr_reg    <= 32'd0;
      wr_en_reg      <= 1'b0;
      wr_data_reg    <= 16'd0;
      pic_done_reg   <= 1'b0;
      init_end_d_reg <= 1'b0;
      rd_busy_d_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      sector_cnt_reg <= sector_cnt_next;
      word_cnt_reg   <= word_cnt_next;
      tmo_cnt_reg    <= tmo_cnt_next;
      err_reg        <= err_next;
      rd_en_reg      <= rd_en_next;
      rd_addr_reg    <= rd_addr_next;
      wr_en_reg      <= wr_en_next;
      wr_data_reg    <= wr_data_next;
      pic_done_reg   <= pic_done_next;
      init_end_d_reg <= init_end;
      rd_busy_d_reg  <= rd_busy;
    end
  end

  assign rd_en        = rd_en_reg;
  assign rd_addr      = rd_addr_reg;
  assign wr_fifo_en   = wr_en_reg;
  assign wr_fifo_data = wr_data_reg;
  assign busy         = (state_reg != S_IDLE);
  assign pic_done     = pic_done_reg;
  assign err          = err_reg;

endmodule

// File: tb/tb_sd_pic_rd_sched.sv
module tb_sd_pic_rd_sched;

  localparam int          CNT_W = 11;
  localparam logic [31:0] START = 32'd16640;

  logic             sys_clk;
  logic             sys_rst_n;
  logic             init_end;
  logic             start;
  logic             rd_busy;
  logic             rd_data_en;
  logic [15:0]      rd_data;
  logic [CNT_W-1:0] fifo_free;
  logic             rd_en;
  logic [31:0]      rd_addr;
  logic             wr_fifo_en;
  logic [15:0]      wr_fifo_data;
  logic             busy;
  logic             pic_done;
  logic             err;

  int checks       = 0;
  int failures     = 0;
  int pic_done_cnt = 0;
  int wr_cnt       = 0;

  logic [15:0] exp_data[$];
  logic [31:0] exp_addr[$];

  // sd_ctrl model knobs
  bit model_no_busy = 0;
  int sector_words  = 256;
  bit word_ok       = 0;

  // monitor state
  bit          mon_pend       = 0;
  bit          mon_rd_en_prev = 0;
  logic [15:0] mon_e;
  logic [31:0] mon_a;

  sd_pic_rd_sched #(
    .START_SECTOR  (START),
    .SECTOR_NUM    (32'd3),
    .WORDS_PER_SEC (9'd256),
    .CNT_W         (CNT_W),
    .TIMEOUT       (24'd1000),
    .AUTO_START    (1'b1)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .init_end     (init_end),
    .start        (start),
    .rd_busy      (rd_busy),
    .rd_data_en   (rd_data_en),
    .rd_data      (rd_data),
    .fifo_free    (fifo_free),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .wr_fifo_en   (wr_fifo_en),
    .wr_fifo_data (wr_fifo_data),
    .busy         (busy),
    .pic_done     (pic_done),
    .err          (err)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_addrs(input int n);
    for (int i = 0; i < n; i++) exp_addr.push_back(START + 32'(i));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while ((busy || rd_busy) && n < budget) begin
      tick(1);
      n++;
    end
    checks++;
    if (busy || rd_busy) begin
      failures++;
      $display("FAIL %s: still busy after %0d cycles", name, budget);
    end
    tick(2);
  endtask

  task automatic wait_addr_left(input int left, input int budget, input string name);
    int n;
    n = 0;
    while (exp_addr.size() > left && n < budget) begin
      tick(1);
      n++;
    end
    checks++;
    if (exp_addr.size() > left) begin
      failures++;
      $display("FAIL %s: %0d requests outstanding, required %0d", name, exp_addr.size(), left);
    end
  endtask

  task automatic do_reset();
    init_end  = 1'b0;
    sys_rst_n = 1'b0;
    tick(3);
    sys_rst_n = 1'b1;
    tick(2);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"}, 32'(rd_en), 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_wr_fifo_en"}, 32'(wr_fifo_en), 0);
    chk({tag, "_wr_fifo_data"}, 32'(wr_fifo_data), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_pic_done"}, 32'(pic_done), 0);
    chk({tag, "_err"}, 32'(err), 0);
  endtask

  // sd_ctrl behaviour: accept a request, raise busy, wait 20 cycles, stream
  // sector_words random words with occasional gaps, then drop busy.
  initial begin : sd_model
    rd_busy    = 1'b0;
    rd_data_en = 1'b0;
    rd_data    = 16'd0;
    forever begin
      @(posedge sys_clk);
      #1;
      if (rd_en && !rd_busy && !model_no_busy) begin
        rd_busy = 1'b1;
        tick(20);
        for (int k = 0; k < sector_words; k++) begin
          rd_data_en = 1'b1;
          rd_data    = 16'($urandom);
          word_ok    = (k < 256);
          tick(1);
          if ($urandom_range(0, 3) == 0) begin
            rd_data_en = 1'b0;
            word_ok    = 1'b0;
            tick(1);
          end
        end
        rd_data_en = 1'b0;
        word_ok    = 1'b0;
        tick(1);
        rd_busy = 1'b0;
      end
    end
  end

  // Scoreboard: a delivered word that a reading scheduler must accept is
  // expected on the FIFO port exactly one cycle later, in order.
  initial begin : monitor
    forever begin
      @(negedge sys_clk);
      if (!sys_rst_n) begin
        mon_pend       = 1'b0;
        mon_rd_en_prev = 1'b0;
        exp_data.delete();
      end else begin
        if (wr_fifo_en || mon_pend) begin
          checks++;
          if (wr_fifo_en !== mon_pend) begin
            failures++;
            $display("FAIL wr_strobe: got %0b expected %0b at %0t", wr_fifo_en, mon_pend, $time);
          end
          if (wr_fifo_en) begin
            wr_cnt++;
            if (exp_data.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL wr_data: got %0h with no word expected", wr_fifo_data);
            end else begin
              mon_e = exp_data.pop_front();
              checks++;
              if (wr_fifo_data !== mon_e) begin
                failures++;
                $display("FAIL wr_data: got %0h expected %0h", wr_fifo_data, mon_e);
              end
            end
          end else if (exp_data.size() != 0) begin
            mon_e = exp_data.pop_front();
          end
        end
        mon_pend = rd_data_en && word_ok && init_end;
        if (mon_pend) exp_data.push_back(rd_data);

        if (rd_en && !mon_rd_en_prev) begin
          checks++;
          if (exp_addr.size() == 0) begin
            failures++;
            $display("FAIL rd_req: got addr %0d with no request expected", rd_addr);
          end else begin
            mon_a = exp_addr.pop_front();
            $display("REQ addr=%0d expected=%0d t=%0t", rd_addr, mon_a, $time);
            if (rd_addr !== mon_a) begin
              failures++;
              $display("FAIL rd_addr: got %0d expected %0d", rd_addr, mon_a);
            end
          end
        end
        mon_rd_en_prev = rd_en;

        if (pic_done) begin
          pic_done_cnt++;
          $display("PIC_DONE count=%0d t=%0t", pic_done_cnt, $time);
        end
      end
    end
  end

  initial begin : stimulus
    int w0;
    int d0;
    int hi;
    int seen;
    int n;

    sys_rst_n = 1'b1;
    init_end  = 1'b0;
    start     = 1'b0;
    fifo_free = 11'd300;
    #2 sys_rst_n = 1'b0;
    #1;
    chk_all_zero("reset");
    tick(3);
    sys_rst_n = 1'b1;
    tick(3);
    chk("idle_busy", 32'(busy), 0);
    pulse_start();
    tick(3);
    chk("start_without_init", 32'(busy), 0);

    // Normal picture: start pulse and init_end rise together -> one run.
    push_addrs(3);
    w0 = wr_cnt;
    d0 = pic_done_cnt;
    init_end = 1'b1;
    start    = 1'b1;
    tick(1);
    start = 1'b0;
    tick(2);
    chk("t1_busy", 32'(busy), 1);
    wait_idle(4000, "t1_run");
    chk("t1_pic_done", 32'(pic_done_cnt - d0), 1);
    chk("t1_writes", 32'(wr_cnt - w0), 768);
    chk("t1_err", 32'(err), 0);
    chk("t1_addr_left", 32'(exp_addr.size()), 0);
    chk("t1_rd_addr_idle", rd_addr, 0);

    // FIFO space gate, plus a start while busy that must be ignored.
    fifo_free = 11'd100;
    push_addrs(3);
    d0 = pic_done_cnt;
    pulse_start();
    hi = 0;
    for (int i = 0; i < 2000; i++) begin
      tick(1);
      if (rd_en) hi++;
    end
    chk("t2_rd_en_while_no_space", 32'(hi), 0);
    chk("t2_busy_waiting", 32'(busy), 1);
    fifo_free = 11'd300;
    seen = 0;
    for (int i = 0; i < 2; i++) begin
      tick(1);
      if (rd_en) seen = 1;
    end
    chk("t2_rd_en_after_space", 32'(seen), 1);
    pulse_start();
    wait_idle(4000, "t2_run");
    chk("t2_pic_done", 32'(pic_done_cnt - d0), 1);
    chk("t2_err", 32'(err), 0);
    chk("t2_addr_left", 32'(exp_addr.size()), 0);

    // Short sector (255 words).
    sector_words = 255;
    exp_addr.push_back(START);
    w0 = wr_cnt;
    d0 = pic_done_cnt;
    pulse_start();
    tick(2);
    wait_idle(2000, "t3_run");
    chk("t3_err", 32'(err), 1);
    chk("t3_pic_done", 32'(pic_done_cnt - d0), 0);
    chk("t3_writes", 32'(wr_cnt - w0), 255);
    sector_words = 256;
    pulse_start();
    tick(3);
    chk("t3_start_after_err", 32'(busy), 0);
    do_reset();
    chk("t3_err_after_reset", 32'(err), 0);

    // Long sector (257 words): surplus word dropped, error flagged.
    sector_words = 257;
    exp_addr.push_back(START);
    w0 = wr_cnt;
    d0 = pic_done_cnt;
    init_end = 1'b1;
    tick(2);
    wait_idle(2000, "t4_run");
    chk("t4_err", 32'(err), 1);
    chk("t4_writes", 32'(wr_cnt - w0), 256);
    chk("t4_pic_done", 32'(pic_done_cnt - d0), 0);
    sector_words = 256;
    do_reset();

    // Timeout: sd_ctrl never answers.
    model_no_busy = 1'b1;
    exp_addr.push_back(START);
    init_end = 1'b1;
    n = 0;
    while (!rd_en && n < 20) begin
      tick(1);
      n++;
    end
    chk("t5_rd_en_rise", 32'(rd_en), 1);
    n = 0;
    while (rd_en && n < 1200) begin
      n++;
      tick(1);
    end
    chk("t5_rd_en_cycles", 32'(n), 1000);
    chk("t5_err", 32'(err), 1);
    chk("t5_rd_en_low", 32'(rd_en), 0);
    chk("t5_busy_low", 32'(busy), 0);
    pulse_start();
    tick(20);
    chk("t5_start_ignored", 32'(busy), 0);
    model_no_busy = 1'b0;
    do_reset();

    // init_end dropped mid-sector 2, then re-raised.
    exp_addr.push_back(START);
    exp_addr.push_back(START + 32'd1);
    d0 = pic_done_cnt;
    init_end = 1'b1;
    wait_addr_left(0, 2000, "t6_second_req");
    tick(60);
    init_end = 1'b0;
    tick(1);
    w0 = wr_cnt;
    chk("t6_busy_abort", 32'(busy), 0);
    chk("t6_rd_en_abort", 32'(rd_en), 0);
    n = 0;
    while (rd_busy && n < 1000) begin
      tick(1);
      n++;
    end
    tick(3);
    chk("t6_no_writes", 32'(wr_cnt - w0), 0);
    chk("t6_no_pic_done", 32'(pic_done_cnt - d0), 0);
    chk("t6_err", 32'(err), 0);
    push_addrs(3);
    init_end = 1'b1;
    tick(2);
    chk("t6_restart_busy", 32'(busy), 1);
    wait_idle(4000, "t6_rerun");
    chk("t6_pic_done", 32'(pic_done_cnt - d0), 1);
    chk("t6_addr_left", 32'(exp_addr.size()), 0);

    // Asynchronous reset in the middle of a sector.
    push_addrs(3);
    pulse_start();
    wait_addr_left(2, 200, "t7_first_req");
    tick(60);
    #1 sys_rst_n = 1'b0;
    #1;
    chk_all_zero("t7_async_reset");
    init_end = 1'b0;
    exp_addr.delete();
    n = 0;
    while (rd_busy && n < 1000) begin
      tick(1);
      n++;
    end
    tick(2);
    sys_rst_n = 1'b1;
    tick(2);
    push_addrs(3);
    w0 = wr_cnt;
    d0 = pic_done_cnt;
    init_end = 1'b1;
    start    = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    wait_idle(4000, "t7_run");
    chk("t7_pic_done", 32'(pic_done_cnt - d0), 1);
    chk("t7_writes", 32'(wr_cnt - w0), 768);
    chk("t7_err", 32'(err), 0);
    chk("t7_addr_left", 32'(exp_addr.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
